// File: rtl/inv_arbiter.sv
// Round-robin arbiter sharing one 2x2 inversion engine among N_REQ requesters.
// Handles the start/done handshake with the engine and bounds the wait with a timeout.
module inv_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic [N_REQ-1:0]         req,
  input  logic                     inv_done,
  output logic                     start_inv,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     timeout_err,
  output logic                     busy
);
  localparam int unsigned SEL_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             err_flag, err_flag_nxt;
  logic [SEL_W-1:0] last, last_nxt, sel_nxt;
  logic [SEL_W-1:0] win, hi_idx, lo_idx;
  logic             hi_found;
  logic             start_inv_nxt, timeout_err_nxt, busy_nxt;
  logic [N_REQ-1:0] grant_nxt, done_nxt;

  assign cnt_inc = cnt + CNT_W'(1);

  // Round-robin pick: lowest requester above last, else lowest at or below last.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (SEL_W'(i) > last) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end else begin
          lo_idx = SEL_W'(i);
        end
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end

  // State and all output registers; nothing moves on clk_en=0 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      err_flag    <= 1'b0;
      last        <= LAST_RST;
      sel         <= '0;
      grant       <= '0;
      done        <= '0;
      start_inv   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else if (clk_en) begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      err_flag    <= err_flag_nxt;
      last        <= last_nxt;
      sel         <= sel_nxt;
      grant       <= grant_nxt;
      done        <= done_nxt;
      start_inv   <= start_inv_nxt;
      timeout_err <= timeout_err_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state logic; completion wins over a timeout landing on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (inv_done || (cnt_inc == CNT_MAX)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    start_inv_nxt   = 1'b0;
    done_nxt        = '0;
    timeout_err_nxt = 1'b0;
    busy_nxt        = (state_nxt != IDLE);
    sel_nxt         = sel;
    grant_nxt       = grant;
    last_nxt        = last;
    cnt_nxt         = cnt;
    err_flag_nxt    = err_flag;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt       = win;
          grant_nxt     = N_REQ'(1) << win;
          start_inv_nxt = 1'b1;
        end
      end
      START: cnt_nxt = '0;
      WAIT: begin
        if (inv_done) begin
          err_flag_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_MAX) err_flag_nxt = 1'b1;
        end
      end
      DONE: begin
        last_nxt  = sel;
        grant_nxt = '0;
      end
      default: ;
    endcase
    if ((state == WAIT) && (state_nxt == DONE)) begin
      done_nxt        = grant;
      timeout_err_nxt = err_flag_nxt;
    end
  end

endmodule

// File: tb/tb_inv_arbiter.sv
// Bench for inv_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inv_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 5;

  logic         clk = 1'b0;
  logic         rst, clk_en, inv_done;
  logic [N-1:0] req;
  logic         start_inv, timeout_err, busy;
  logic [1:0]   sel;
  logic [N-1:0] grant, done;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  inv_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .inv_done(inv_done),
    .start_inv(start_inv), .sel(sel), .grant(grant), .done(done),
    .timeout_err(timeout_err), .busy(busy)
  );

  // Reference model, tracked per transaction rather than per FSM state.
  bit m_active, m_started, m_waiting, m_fin, m_err;
  int m_win, m_sel, m_last, m_waited;

  task automatic model_reset();
    m_active = 0; m_started = 0; m_waiting = 0; m_fin = 0; m_err = 0;
    m_win = 0; m_sel = 0; m_last = N - 1; m_waited = 0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int idx;
    rr_pick = -1;
    for (int k = N; k >= 1; k--) begin
      idx = (last + k) % N;
      if (r[idx[1:0]]) rr_pick = idx;
    end
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    oh = N'(1) << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && clk_en) begin
      m_started = 0;
      if (!m_active) begin
        if (req != '0) begin
          m_win = rr_pick(req, m_last); m_sel = m_win;
          m_active = 1; m_started = 1; m_waiting = 0; m_waited = 0; m_fin = 0;
        end
      end else if (m_fin) begin
        m_active = 0; m_fin = 0; m_err = 0; m_last = m_win;
      end else if (!m_waiting) begin
        m_waiting = 1;
      end else begin
        m_waited++;
        if (inv_done) begin m_fin = 1; m_err = 0; end
        else if (m_waited == TO) begin m_fin = 1; m_err = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_start_inv", 32'(start_inv), 32'(m_started));
      check("cyc_busy", 32'(busy), 32'(m_active));
      check("cyc_sel", 32'(sel), 32'(m_sel));
      check("cyc_grant", 32'(grant), 32'(m_active ? oh(m_win) : 4'b0));
      check("cyc_done", 32'(done), 32'(m_fin ? oh(m_win) : 4'b0));
      check("cyc_timeout_err", 32'(timeout_err), 32'(m_fin && m_err));
    end
  end

  // Reset pulse starting mid-cycle; outputs must clear before any clock edge.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    model_reset();
    #1 check("rst_async", 32'({start_inv, sel, grant, done, timeout_err, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int got[5];
  int exp_order[5];
  int n, waits, nb, ns, nd;
  bit seen;

  initial begin
    rst = 1'b1; clk_en = 1'b0; req = '0; inv_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 32'({start_inv, sel, grant, done, timeout_err, busy}), 32'd0);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Single request, done on first WAIT cycle.
    req = 4'b0100; clk_en = 1'b1;
    @(negedge clk);
    check("s1_grant", 32'(grant), 32'h4);
    check("s1_sel", 32'(sel), 32'd2);
    check("s1_start", 32'(start_inv), 32'd1);
    req = '0;
    @(negedge clk);
    check("s1_start_once", 32'(start_inv), 32'd0);
    inv_done = 1'b1;
    @(negedge clk);
    inv_done = 1'b0;
    check("s1_done", 32'(done), 32'h4);
    check("s1_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("s1_busy_low", 32'(busy), 32'd0);
    check("s1_done_once", 32'(done), 32'd0);

    // All requesting: rotation 0,1,2,3,0.
    pulse_rst();
    req = 4'hF; inv_done = 1'b1; n = 0;
    for (int k = 0; k < 5; k++) got[k] = -1;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (start_inv) begin got[n] = int'(sel); n++; end
    end
    for (int k = 0; k < 5; k++) check("s2_rr_order", 32'(got[k]), 32'(exp_order[k]));

    // Timeout after TO wait cycles, then a clean transaction.
    inv_done = 1'b0; pulse_rst();
    req = 4'b0001; waits = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (start_inv) req = '0;
      if (done != '0) begin
        seen = 1;
        check("s3_done", 32'(done), 32'h1);
        check("s3_terr", 32'(timeout_err), 32'd1);
      end else if (busy && !start_inv) waits++;
    end
    check("s3_seen", 32'(seen), 32'd1);
    check("s3_wait_cycles", 32'(waits), 32'(TO));
    req = 4'b0001; inv_done = 1'b1; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (start_inv) req = '0;
      if (done != '0) begin
        seen = 1;
        check("s3b_done", 32'(done), 32'h1);
        check("s3b_terr", 32'(timeout_err), 32'd0);
      end
    end
    check("s3b_seen", 32'(seen), 32'd1);

    // inv_done on the same edge the count reaches TIMEOUT.
    inv_done = 1'b0; pulse_rst();
    req = 4'b0001; waits = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (start_inv) req = '0;
      inv_done = 1'b0;
      if (done != '0) begin
        seen = 1;
        check("s4_done", 32'(done), 32'h1);
        check("s4_terr", 32'(timeout_err), 32'd0);
      end else if (busy && !start_inv) begin
        waits++;
        if (waits == TO) inv_done = 1'b1;
      end
    end
    check("s4_seen", 32'(seen), 32'd1);

    // clk_en alternating: every phase lasts two clocks.
    inv_done = 1'b0; pulse_rst();
    req = 4'b0100; clk_en = 1'b1; inv_done = 1'b1; nb = 0; ns = 0; nd = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (start_inv) req = '0;
      if (busy) nb++;
      if (start_inv) ns++;
      if (done != '0) nd++;
      clk_en = (k % 2 == 0);
    end
    check("s5_busy_clocks", 32'(nb), 32'd6);
    check("s5_start_clocks", 32'(ns), 32'd2);
    check("s5_done_clocks", 32'(nd), 32'd2);
    clk_en = 1'b1;

    // Reset during WAIT abandons the transaction; priority restarts at 0.
    inv_done = 1'b0; pulse_rst();
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    check("s6_grant_wait", 32'(grant), 32'h2);
    pulse_rst();
    req = 4'b1010;
    @(negedge clk);
    check("s6_regrant", 32'(grant), 32'h2);
    check("s6_sel", 32'(sel), 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) pulse_rst();
      req      = 4'($urandom) & 4'($urandom);
      clk_en   = ($urandom_range(0, 3) != 0);
      inv_done = ($urandom_range(0, 5) == 0);
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_arbiter.md
INV_ARBITER -- requirements
Module: inv_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one 2x2 inversion engine (2..8).
REQ-002 Parameter TIMEOUT, default 255, maximum enabled cycles to wait for engine completion (1..65535).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clk_en  input  1  clock enable (MATLAB rate); state advances only on edges where clk_en=1.
REQ-006 req  input  N_REQ  per-requester inversion request, level-sensitive.
REQ-007 inv_done  input  1  engine completion pulse (endInv of the inversion engine).
REQ-008 start_inv  output  1  start pulse to the engine (startInv).
REQ-009 sel  output  clog2(N_REQ)  index of the granted requester; steers the engine's matrix input mux and result capture.
REQ-010 grant  output  N_REQ  one-hot grant, held for the whole transaction.
REQ-011 done  output  N_REQ  one-hot completion pulse to the granted requester.
REQ-012 timeout_err  output  1  pulse: transaction ended by timeout, not by inv_done.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 All outputs are registered; the FSM has states IDLE, START, WAIT and DONE.
REQ-015 On an edge with clk_en=0, every register holds its value, including the timeout counter.
REQ-016 IDLE: if req!=0, select the winner round-robin, searching from index last+1 upward with wrap; load sel and grant; go to START; otherwise stay in IDLE.
REQ-017 START: start_inv=1 for exactly one enabled cycle; clear the counter; go to WAIT.
REQ-018 WAIT: if inv_done=1, go to DONE with err_flag=0; otherwise increment the counter.
REQ-019 WAIT: if the counter reaches TIMEOUT without inv_done, go to DONE with err_flag=1.
REQ-020 WAIT: inv_done and counter==TIMEOUT on the same edge resolve as normal completion, with no error.
REQ-021 DONE: done[sel]=1 and timeout_err=err_flag for one enabled cycle; set last=sel; clear grant; go to IDLE.
REQ-022 inv_done is ignored in IDLE, START and DONE.
REQ-023 A requester dropping req mid-transaction does not abort; done still pulses for it.
REQ-024 A requester still asserting req after its done is eligible again, but only after all other active requesters in round-robin order.
REQ-025 Minimum transaction = 4 enabled cycles (IDLE->START->WAIT->DONE) when inv_done arrives on the first WAIT cycle.
REQ-026 Back-to-back requests lose one IDLE cycle between transactions; that cycle performs arbitration.
REQ-027 The counter width is clog2(TIMEOUT+1) bits; it never wraps, because it stops at TIMEOUT.

Reset
REQ-028 While rst=1, and immediately on its assertion, regardless of clk_en: state=IDLE, start_inv=0, sel=0, grant=0, done=0, timeout_err=0, busy=0, counter=0, err_flag=0, last=N_REQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-transaction abandons the transaction with no done pulse; after release the arbiter re-arbitrates from priority 0.

Verification
REQ-030 clk_en=1, req=4'b0100, inv_done pulsed on the 1st WAIT cycle -> grant=0100, sel=2, start_inv for 1 cycle, done=0100 in cycle 4, busy low in cycle 5.
REQ-031 req=4'b1111 held, inv_done each transaction -> grant order 0,1,2,3,0; each done pulse is one-hot and matches the preceding grant.
REQ-032 req=4'b0001, inv_done never asserted, TIMEOUT=5 -> done=0001 with timeout_err=1 after 5 WAIT cycles; the next transaction starts cleanly.
REQ-033 inv_done coincident with counter==TIMEOUT -> done pulse, timeout_err=0.
REQ-034 clk_en toggling 1,0,1,0 during a transaction -> state, counter and outputs frozen on clk_en=0 edges; total transaction spans twice the enabled-cycle count.
REQ-035 rst pulsed while in WAIT with grant=0010 -> all outputs 0 asynchronously; with req=4'b1010 afterwards, requester 1 is granted first.
